// File: rtl/text_console_ctrl.sv
// Console front end for the 40x30 text video driver: turns a byte stream into
// cell writes, tracks the cursor, and scrolls/clears the text RAM in place.
//
// state   | meaning
// IDLE    | char_ready high, waiting for a byte
// CLR_RD  | reading the cell under the cursor
// CLR_WR  | writing it back with the cursor bit cleared
// EXEC    | decode byte: char write / cursor move / start scroll or clear
// SCR_RD  | reading cell i+COLS during scroll-up
// SCR_WR  | writing that data to cell i
// FILL    | blanking cells up to the last cell, one per cycle
// SET_RD  | reading the new cursor cell
// SET_WR  | writing it back with the cursor bit set
module text_console_ctrl #(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    input  logic [5:0]  attr,
    output logic        char_ready,
    output logic        we,
    output logic [10:0] mem_addr,
    output logic [15:0] mem_data,
    input  logic [15:0] ret_data,
    output logic [5:0]  cur_col,
    output logic [4:0]  cur_row
);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_CLR_RD = 4'd1;
    localparam logic [3:0] ST_CLR_WR = 4'd2;
    localparam logic [3:0] ST_EXEC   = 4'd3;
    localparam logic [3:0] ST_SCR_RD = 4'd4;
    localparam logic [3:0] ST_SCR_WR = 4'd5;
    localparam logic [3:0] ST_FILL   = 4'd6;
    localparam logic [3:0] ST_SET_RD = 4'd7;
    localparam logic [3:0] ST_SET_WR = 4'd8;

    localparam logic [10:0] COLS_A        = 11'(COLS);
    localparam logic [10:0] LAST_CELL     = 11'(COLS * ROWS - 1);
    localparam logic [10:0] SCR_LAST      = 11'(COLS * (ROWS - 1) - 1);
    localparam logic [10:0] LAST_ROW_BASE = 11'(COLS * (ROWS - 1));
    localparam logic [5:0]  COL_MAX       = 6'(COLS - 1);
    localparam logic [4:0]  ROW_MAX       = 5'(ROWS - 1);

    logic [3:0]  state;
    logic [7:0]  char_l;
    logic [5:0]  attr_l;

    logic        is_print;
    logic        is_ff;
    logic        row_inc;
    logic        need_scroll;
    logic [5:0]  nxt_col;
    logic [4:0]  nxt_row;
    logic [10:0] cur_addr;
    logic [10:0] nxt_addr;
    logic [15:0] fill_word;

    function automatic logic [10:0] cell_addr(input logic [4:0] r, input logic [5:0] c);
        return 11'(r) * COLS_A + 11'(c);
    endfunction

    always_comb begin
        is_print    = (char_l >= 8'h20) && (char_l <= 8'h7E);
        is_ff       = (char_l == 8'h0C);
        row_inc     = 1'b0;
        need_scroll = 1'b0;
        nxt_col     = cur_col;
        nxt_row     = cur_row;
        if (is_print) begin
            if (cur_col == COL_MAX) begin
                nxt_col = 6'd0;
                row_inc = 1'b1;
            end else begin
                nxt_col = cur_col + 6'd1;
            end
        end else begin
            case (char_l)
                8'h0D: nxt_col = 6'd0;
                8'h0A: begin
                    nxt_col = 6'd0;
                    row_inc = 1'b1;
                end
                8'h08: if (cur_col != 6'd0) nxt_col = cur_col - 6'd1;
                8'h0C: begin
                    nxt_col = 6'd0;
                    nxt_row = 5'd0;
                end
                default: ;
            endcase
        end
        // On the bottom row the cursor stays put and the screen moves instead
        if (row_inc) begin
            if (cur_row == ROW_MAX) need_scroll = 1'b1;
            else                    nxt_row     = cur_row + 5'd1;
        end
        cur_addr  = cell_addr(cur_row, cur_col);
        nxt_addr  = cell_addr(nxt_row, nxt_col);
        fill_word = {2'b00, attr_l, 8'h00};
    end

    // Outputs are registered alongside the state they belong to, so every
    // transition below also loads the bus values for the state being entered.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= ST_FILL;
            we         <= 1'b0;
            mem_addr   <= 11'd0;
            mem_data   <= 16'h0000;
            char_ready <= 1'b0;
            cur_col    <= 6'd0;
            cur_row    <= 5'd0;
            char_l     <= 8'h00;
            attr_l     <= 6'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (char_valid) begin
                        char_l     <= char_data;
                        attr_l     <= attr;
                        char_ready <= 1'b0;
                        we         <= 1'b0;
                        mem_addr   <= cur_addr;
                        state      <= ST_CLR_RD;
                    end
                end
                ST_CLR_RD: begin
                    we       <= 1'b1;
                    mem_data <= {2'b00, ret_data[13:0]};
                    state    <= ST_CLR_WR;
                end
                ST_CLR_WR: begin
                    we       <= is_print;
                    mem_data <= {2'b00, attr_l, char_l};
                    state    <= ST_EXEC;
                end
                ST_EXEC: begin
                    cur_col <= nxt_col;
                    cur_row <= nxt_row;
                    if (is_ff) begin
                        we       <= 1'b1;
                        mem_addr <= 11'd0;
                        mem_data <= fill_word;
                        state    <= ST_FILL;
                    end else if (need_scroll) begin
                        we       <= 1'b0;
                        mem_addr <= COLS_A;
                        state    <= ST_SCR_RD;
                    end else begin
                        we       <= 1'b0;
                        mem_addr <= nxt_addr;
                        state    <= ST_SET_RD;
                    end
                end
                ST_SCR_RD: begin
                    we       <= 1'b1;
                    mem_addr <= mem_addr - COLS_A;
                    mem_data <= ret_data;
                    state    <= ST_SCR_WR;
                end
                ST_SCR_WR: begin
                    if (mem_addr == SCR_LAST) begin
                        we       <= 1'b1;
                        mem_addr <= LAST_ROW_BASE;
                        mem_data <= fill_word;
                        state    <= ST_FILL;
                    end else begin
                        we       <= 1'b0;
                        mem_addr <= mem_addr + COLS_A + 11'd1;
                        state    <= ST_SCR_RD;
                    end
                end
                ST_FILL: begin
                    // Coming out of reset we is still low, so the first write lands on 0
                    if (we && (mem_addr == LAST_CELL)) begin
                        we       <= 1'b0;
                        mem_addr <= cur_addr;
                        state    <= ST_SET_RD;
                    end else begin
                        we       <= 1'b1;
                        mem_addr <= mem_addr + {10'd0, we};
                        mem_data <= fill_word;
                    end
                end
                ST_SET_RD: begin
                    we       <= 1'b1;
                    mem_data <= {2'b01, ret_data[13:0]};
                    state    <= ST_SET_WR;
                end
                ST_SET_WR: begin
                    we         <= 1'b0;
                    char_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    we       <= 1'b0;
                    mem_addr <= 11'd0;
                    state    <= ST_FILL;
                end
            endcase
        end
    end

endmodule
